// File: rtl/id_ex_if.sv
// Decode-to-EX bundle for the ID/EX pipeline register: decoded inputs, registered
// EX-side outputs, the combinational stall back to fetch and the bubble counter.
interface id_ex_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
);
   logic             valid_i;
   logic             reg_write_i, mem_to_reg_i, mem_write_i, mem_read_i;
   logic             branch_i, alu_src_i, lui_i, alu_op_i, auipc_i;
   logic [1:0]       jump_i;
   logic             illegal_i;
   logic             uses_rs1_i, uses_rs2_i;
   logic [4:0]       rs1_addr_i, rs2_addr_i, rd_addr_i;
   logic [2:0]       funct3_i;
   logic             funct7b5_i;
   logic [XLEN-1:0]  pc_i, rs1_data_i, rs2_data_i, imm_i;
   logic             flush_i;

   logic             valid_o;
   logic             reg_write_o, mem_to_reg_o, mem_write_o, mem_read_o;
   logic             branch_o, alu_src_o, lui_o, alu_op_o, auipc_o;
   logic [1:0]       jump_o;
   logic             illegal_o;
   logic [4:0]       rs1_addr_o, rs2_addr_o, rd_addr_o;
   logic [2:0]       funct3_o;
   logic             funct7b5_o;
   logic [XLEN-1:0]  pc_o, rs1_data_o, rs2_data_o, imm_o;
   logic             stall_o;
   logic [CNT_W-1:0] bubble_cnt_o;

   modport slave (
      input  valid_i, reg_write_i, mem_to_reg_i, mem_write_i, mem_read_i,
             branch_i, alu_src_i, lui_i, alu_op_i, auipc_i, jump_i, illegal_i,
             uses_rs1_i, uses_rs2_i, rs1_addr_i, rs2_addr_i, rd_addr_i,
             funct3_i, funct7b5_i, pc_i, rs1_data_i, rs2_data_i, imm_i, flush_i,
      output valid_o, reg_write_o, mem_to_reg_o, mem_write_o, mem_read_o,
             branch_o, alu_src_o, lui_o, alu_op_o, auipc_o, jump_o, illegal_o,
             rs1_addr_o, rs2_addr_o, rd_addr_o, funct3_o, funct7b5_o,
             pc_o, rs1_data_o, rs2_data_o, imm_o, stall_o, bubble_cnt_o
   );

   modport master (
      output valid_i, reg_write_i, mem_to_reg_i, mem_write_i, mem_read_i,
             branch_i, alu_src_i, lui_i, alu_op_i, auipc_i, jump_i, illegal_i,
             uses_rs1_i, uses_rs2_i, rs1_addr_i, rs2_addr_i, rd_addr_i,
             funct3_i, funct7b5_i, pc_i, rs1_data_i, rs2_data_i, imm_i, flush_i,
      input  valid_o, reg_write_o, mem_to_reg_o, mem_write_o, mem_read_o,
             branch_o, alu_src_o, lui_o, alu_op_o, auipc_o, jump_o, illegal_o,
             rs1_addr_o, rs2_addr_o, rd_addr_o, funct3_o, funct7b5_o,
             pc_o, rs1_data_o, rs2_data_o, imm_o, stall_o, bubble_cnt_o
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core: load-use hazard detection, bubble
// insertion on stall/flush, illegal-opcode side-effect suppression, bubble counter.
module id_ex_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input logic   clk,
   input logic   rst,
   id_ex_if.slave bus
);
   logic             valid_q, illegal_q;
   logic             reg_write_q, mem_to_reg_q, mem_write_q, mem_read_q;
   logic             branch_q, alu_src_q, lui_q, alu_op_q, auipc_q;
   logic [1:0]       jump_q;
   logic [4:0]       rs1_addr_q, rs2_addr_q, rd_addr_q;
   logic [2:0]       funct3_q;
   logic             funct7b5_q;
   logic [XLEN-1:0]  pc_q, rs1_data_q, rs2_data_q, imm_q;
   logic [CNT_W-1:0] cnt_q;

   logic hz, bubble, live, effect;

   always_comb begin
      hz = valid_q & mem_read_q & (rd_addr_q != 5'd0) & bus.valid_i &
           ((bus.uses_rs1_i & (bus.rs1_addr_i == rd_addr_q)) |
            (bus.uses_rs2_i & (bus.rs2_addr_i == rd_addr_q)));
      bubble = bus.flush_i | hz;
      live   = bus.valid_i;
      effect = bus.valid_i & ~bus.illegal_i;
   end

   assign bus.stall_o = hz & ~bus.flush_i & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q      <= 1'b0;
         illegal_q    <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         branch_q     <= 1'b0;
         alu_src_q    <= 1'b0;
         lui_q        <= 1'b0;
         alu_op_q     <= 1'b0;
         auipc_q      <= 1'b0;
         jump_q       <= '0;
         rs1_addr_q   <= '0;
         rs2_addr_q   <= '0;
         rd_addr_q    <= '0;
         funct3_q     <= '0;
         funct7b5_q   <= 1'b0;
         pc_q         <= '0;
         rs1_data_q   <= '0;
         rs2_data_q   <= '0;
         imm_q        <= '0;
         cnt_q        <= '0;
      end else begin
         // Operand fields load unconditionally; a bubble is defined by valid/controls only.
         rs1_addr_q <= bus.rs1_addr_i;
         rs2_addr_q <= bus.rs2_addr_i;
         rd_addr_q  <= bus.rd_addr_i;
         funct3_q   <= bus.funct3_i;
         funct7b5_q <= bus.funct7b5_i;
         pc_q       <= bus.pc_i;
         rs1_data_q <= bus.rs1_data_i;
         rs2_data_q <= bus.rs2_data_i;
         imm_q      <= bus.imm_i;
         if (bubble) begin
            valid_q      <= 1'b0;
            illegal_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            branch_q     <= 1'b0;
            alu_src_q    <= 1'b0;
            lui_q        <= 1'b0;
            alu_op_q     <= 1'b0;
            auipc_q      <= 1'b0;
            jump_q       <= '0;
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
         end else begin
            valid_q      <= live;
            illegal_q    <= live & bus.illegal_i;
            reg_write_q  <= effect & bus.reg_write_i;
            mem_write_q  <= effect & bus.mem_write_i;
            mem_read_q   <= effect & bus.mem_read_i;
            branch_q     <= effect & bus.branch_i;
            jump_q       <= effect ? bus.jump_i : 2'b00;
            mem_to_reg_q <= live & bus.mem_to_reg_i;
            alu_src_q    <= live & bus.alu_src_i;
            lui_q        <= live & bus.lui_i;
            alu_op_q     <= live & bus.alu_op_i;
            auipc_q      <= live & bus.auipc_i;
         end
      end
   end

   assign bus.valid_o      = valid_q;
   assign bus.illegal_o    = illegal_q;
   assign bus.reg_write_o  = reg_write_q;
   assign bus.mem_to_reg_o = mem_to_reg_q;
   assign bus.mem_write_o  = mem_write_q;
   assign bus.mem_read_o   = mem_read_q;
   assign bus.branch_o     = branch_q;
   assign bus.alu_src_o    = alu_src_q;
   assign bus.lui_o        = lui_q;
   assign bus.alu_op_o     = alu_op_q;
   assign bus.auipc_o      = auipc_q;
   assign bus.jump_o       = jump_q;
   assign bus.rs1_addr_o   = rs1_addr_q;
   assign bus.rs2_addr_o   = rs2_addr_q;
   assign bus.rd_addr_o    = rd_addr_q;
   assign bus.funct3_o     = funct3_q;
   assign bus.funct7b5_o   = funct7b5_q;
   assign bus.pc_o         = pc_q;
   assign bus.rs1_data_o   = rs1_data_q;
   assign bus.rs2_data_o   = rs2_data_q;
   assign bus.imm_o        = imm_q;
   assign bus.bubble_cnt_o = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed plus randomized bench for id_ex_stage against an instruction-level
// model of the EX slot; a 2-bit counter exposes saturation quickly.
module tb_id_ex_stage;
   localparam int unsigned XLEN    = 32;
   localparam int unsigned CNT_W   = 2;
   localparam int          CNT_MAX = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   id_ex_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
   id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int total = 0;
   int bad   = 0;

   // Model of what EX holds; ctrl bits {rw,m2r,mw,mr,br,as,lui,aop,aui,jump[1:0],ill}
   logic        m_valid, m_known;
   logic [11:0] m_ctrl;
   logic [4:0]  m_rs1a, m_rs2a, m_rda;
   logic [2:0]  m_f3;
   logic        m_f7;
   logic [31:0] m_pc, m_d1, m_d2, m_imm;
   int          m_cnt;
   logic        last_stall;

   function automatic logic [11:0] ctrl_in();
      return {bus.reg_write_i, bus.mem_to_reg_i, bus.mem_write_i, bus.mem_read_i,
              bus.branch_i, bus.alu_src_i, bus.lui_i, bus.alu_op_i, bus.auipc_i,
              bus.jump_i, bus.illegal_i};
   endfunction

   function automatic logic [11:0] ctrl_out();
      return {bus.reg_write_o, bus.mem_to_reg_o, bus.mem_write_o, bus.mem_read_o,
              bus.branch_o, bus.alu_src_o, bus.lui_o, bus.alu_op_o, bus.auipc_o,
              bus.jump_o, bus.illegal_o};
   endfunction

   // A valid load in EX whose destination the incoming instruction reads
   function automatic logic hazard();
      if (!(m_valid && m_ctrl[8] && m_rda != 5'd0 && bus.valid_i)) return 1'b0;
      return (bus.uses_rs1_i && bus.rs1_addr_i == m_rda) ||
             (bus.uses_rs2_i && bus.rs2_addr_i == m_rda);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         m_valid = 1'b0; m_ctrl = '0; m_known = 1'b1; m_cnt = 0;
         m_rs1a = '0; m_rs2a = '0; m_rda = '0; m_f3 = '0; m_f7 = 1'b0;
         m_pc = '0; m_d1 = '0; m_d2 = '0; m_imm = '0;
      end else if (bus.flush_i || hazard()) begin
         m_valid = 1'b0; m_ctrl = '0; m_known = 1'b0;
         if (m_cnt < CNT_MAX) m_cnt++;
      end else if (!bus.valid_i) begin
         m_valid = 1'b0; m_ctrl = '0; m_known = 1'b0;
      end else begin
         m_valid = 1'b1; m_known = 1'b1;
         m_ctrl  = ctrl_in();
         if (bus.illegal_i) m_ctrl = m_ctrl & 12'h479;
         m_rs1a = bus.rs1_addr_i; m_rs2a = bus.rs2_addr_i; m_rda = bus.rd_addr_i;
         m_f3 = bus.funct3_i; m_f7 = bus.funct7b5_i;
         m_pc = bus.pc_i; m_d1 = bus.rs1_data_i; m_d2 = bus.rs2_data_i; m_imm = bus.imm_i;
      end
   endtask

   task automatic check_outputs();
      check("valid", 32'(bus.valid_o), 32'(m_valid));
      check("ctrl", 32'(ctrl_out()), 32'(m_ctrl));
      check("bubble_cnt", 32'(bus.bubble_cnt_o), 32'(m_cnt));
      if (m_known) begin
         check("addrs", {15'd0, bus.rs1_addr_o, bus.rs2_addr_o, bus.rd_addr_o, bus.funct3_o, bus.funct7b5_o},
               {15'd0, m_rs1a, m_rs2a, m_rda, m_f3, m_f7});
         check("pc", bus.pc_o, m_pc);
         check("rs1_data", bus.rs1_data_o, m_d1);
         check("rs2_data", bus.rs2_data_o, m_d2);
         check("imm", bus.imm_o, m_imm);
      end
   endtask

   // Inputs are set before the call; stall is checked before the edge, outputs after
   task automatic step();
      logic exp_stall;
      #1;
      exp_stall  = hazard() & ~bus.flush_i & ~rst;
      last_stall = exp_stall;
      check("stall", 32'(bus.stall_o), 32'(exp_stall));
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic set_idle();
      bus.valid_i = 0; bus.reg_write_i = 0; bus.mem_to_reg_i = 0; bus.mem_write_i = 0;
      bus.mem_read_i = 0; bus.branch_i = 0; bus.alu_src_i = 0; bus.lui_i = 0;
      bus.alu_op_i = 0; bus.auipc_i = 0; bus.jump_i = 2'b00; bus.illegal_i = 0;
      bus.uses_rs1_i = 0; bus.uses_rs2_i = 0; bus.rs1_addr_i = 0; bus.rs2_addr_i = 0;
      bus.rd_addr_i = 0; bus.funct3_i = 0; bus.funct7b5_i = 0; bus.pc_i = 0;
      bus.rs1_data_i = 0; bus.rs2_data_i = 0; bus.imm_i = 0; bus.flush_i = 0;
   endtask

   task automatic rand_in();
      logic [15:0] r;
      r = 16'($urandom);
      bus.valid_i = ($urandom_range(0, 7) != 0);
      {bus.reg_write_i, bus.mem_to_reg_i, bus.mem_write_i, bus.mem_read_i, bus.branch_i,
       bus.alu_src_i, bus.lui_i, bus.alu_op_i, bus.auipc_i, bus.jump_i,
       bus.uses_rs1_i, bus.uses_rs2_i, bus.funct7b5_i} = r[14:0];
      bus.illegal_i  = ($urandom_range(0, 5) == 0);
      bus.rs1_addr_i = 5'($urandom_range(0, 3));
      bus.rs2_addr_i = 5'($urandom_range(0, 3));
      bus.rd_addr_i  = 5'($urandom_range(0, 3));
      bus.funct3_i   = 3'($urandom);
      bus.pc_i = $urandom; bus.rs1_data_i = $urandom; bus.rs2_data_i = $urandom; bus.imm_i = $urandom;
   endtask

   task automatic load_x(input logic [4:0] rd);
      set_idle();
      bus.valid_i = 1; bus.mem_read_i = 1; bus.mem_to_reg_i = 1; bus.reg_write_i = 1;
      bus.alu_src_i = 1; bus.uses_rs1_i = 1; bus.rs1_addr_i = 5'd1; bus.rd_addr_i = rd;
      bus.funct3_i = 3'b010; bus.pc_i = 32'h200; bus.imm_i = 32'h10;
   endtask

   task automatic add_x(input logic [4:0] rs2);
      set_idle();
      bus.valid_i = 1; bus.reg_write_i = 1; bus.alu_op_i = 1;
      bus.uses_rs1_i = 1; bus.uses_rs2_i = 1; bus.rs1_addr_i = 5'd2; bus.rs2_addr_i = rs2;
      bus.rd_addr_i = 5'd6; bus.pc_i = 32'h204; bus.rs1_data_i = 32'h11; bus.rs2_data_i = 32'h22;
   endtask

   initial begin
      int seq[5];
      seq = '{1, 2, 3, 3, 3};
      set_idle();
      last_stall = 1'b0;

      // Reset with random inputs
      rand_in(); rst = 1; step(); rand_in(); step();
      check("reset_cnt", 32'(bus.bubble_cnt_o), 32'd0);
      check("reset_valid", 32'(bus.valid_o), 32'd0);
      rst = 0;

      // Pass-through
      set_idle();
      bus.valid_i = 1; bus.reg_write_i = 1; bus.alu_op_i = 1;
      bus.pc_i = 32'h100; bus.rs1_data_i = 32'hDEADBEEF;
      step();
      check("pt_valid", 32'(bus.valid_o), 32'd1);
      check("pt_pc", bus.pc_o, 32'h100);
      check("pt_rs1", bus.rs1_data_o, 32'hDEADBEEF);

      // Load-use: one stall, bubble, then the add goes through
      rst = 1; set_idle(); step(); rst = 0;
      load_x(5'd5); step();
      add_x(5'd5); step();
      check("lu_stalled", 32'(last_stall), 32'd1);
      check("lu_bubble", 32'(bus.valid_o), 32'd0);
      check("lu_cnt", 32'(bus.bubble_cnt_o), 32'd1);
      step();
      check("lu_released", 32'(last_stall), 32'd0);
      check("lu_add_rd", 32'(bus.rd_addr_o), 32'd6);

      // Load to x0 never stalls
      rst = 1; set_idle(); step(); rst = 0;
      load_x(5'd0); step();
      add_x(5'd0); step();
      check("x0_nostall", 32'(last_stall), 32'd0);
      check("x0_valid", 32'(bus.valid_o), 32'd1);

      // Flush concurrent with a hazard counts once
      rst = 1; set_idle(); step(); rst = 0;
      load_x(5'd5); step();
      add_x(5'd5); bus.flush_i = 1; step();
      check("fl_nostall", 32'(last_stall), 32'd0);
      check("fl_cnt", 32'(bus.bubble_cnt_o), 32'd1);
      bus.flush_i = 0;

      // Illegal opcode loses its side effects
      set_idle();
      bus.valid_i = 1; bus.illegal_i = 1; bus.reg_write_i = 1; bus.mem_write_i = 1; bus.jump_i = 2'b01;
      step();
      check("ill_flag", 32'(bus.illegal_o), 32'd1);
      check("ill_effects", {29'd0, bus.reg_write_o, bus.mem_write_o, |bus.jump_o}, 32'd0);

      // Counter saturation
      rst = 1; set_idle(); step(); rst = 0;
      for (int i = 0; i < 5; i++) begin
         bus.flush_i = 1; step();
         check("sat_cnt", 32'(bus.bubble_cnt_o), 32'(seq[i]));
      end
      bus.flush_i = 0;

      // Random traffic; upstream re-presents the same instruction after a stall
      for (int i = 0; i < 400; i++) begin
         if (!last_stall) rand_in();
         bus.flush_i = ($urandom_range(0, 5) == 0);
         rst = ($urandom_range(0, 49) == 0);
         step();
      end
      rst = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the RV32I core. Sits directly downstream of the opcode decoder (control unit) and the register file.
- Each cycle it latches the decoded control bundle plus operands into the EX stage.
- It detects load-use hazards and inserts bubbles on stall or on flush (taken branch or jump).
- It suppresses side effects of illegal opcodes and keeps a saturating count of inserted bubbles.

Parameters:
- XLEN, 32, datapath width of PC, operands and immediate.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  decode stage holds a real instruction.
- reg_write_i, mem_to_reg_i, mem_write_i, mem_read_i, branch_i, alu_src_i, lui_i, alu_op_i, auipc_i  in  1 each  decoded control signals.
- jump_i  in  2  00 none, 01 JAL, 10 JALR.
- illegal_i  in  1  decoder flagged an unknown opcode.
- uses_rs1_i, uses_rs2_i  in  1 each  instruction reads rs1 / rs2.
- rs1_addr_i, rs2_addr_i, rd_addr_i  in  5 each  register indices.
- funct3_i  in  3;  funct7b5_i  in  1  ALU sub-op bits.
- pc_i, rs1_data_i, rs2_data_i, imm_i  in  XLEN each.
- flush_i  in  1  EX resolved a taken branch or jump; kill the instruction entering EX.
- valid_o  out  1  EX-stage instruction valid.
- reg_write_o, mem_to_reg_o, mem_write_o, mem_read_o, branch_o, alu_src_o, lui_o, alu_op_o, auipc_o  out  1 each  registered controls.
- jump_o  out  2.
- illegal_o  out  1  EX holds an illegal instruction (exception request).
- rs1_addr_o, rs2_addr_o, rd_addr_o  out  5 each;  funct3_o  out  3;  funct7b5_o  out  1.
- pc_o, rs1_data_o, rs2_data_o, imm_o  out  XLEN each.
- stall_o  out  1  combinational; hold PC and IF/ID this cycle.
- bubble_cnt_o  out  CNT_W  saturating count of inserted bubbles.

Behaviour:
- Reset: every registered output is 0, including valid_o, all controls, jump_o=00, illegal_o, addresses, data and bubble_cnt_o.
- stall_o is 0 while rst is asserted.
- Latency: one cycle from decode inputs to the _o outputs.
- Load-use hazard is combinational:
  - hz = valid_o & mem_read_o & (rd_addr_o != 0) & valid_i & ((uses_rs1_i & rs1_addr_i == rd_addr_o) | (uses_rs2_i & rs2_addr_i == rd_addr_o)).
  - stall_o = hz & ~flush_i.
- Per-edge priority, highest first:
  1. rst: load reset state.
  2. flush_i: load bubble.
  3. hz: load bubble; upstream holds, so the same instruction is re-presented next cycle.
  4. Otherwise load the inputs.
- Bubble definition: valid_o=0, all controls 0, jump_o=00, illegal_o=0. Data and address fields may be loaded or held, and EX must not rely on them.
- Normal load with valid_i=0: same as a bubble, but bubble_cnt_o does not increment.
- Normal load with valid_i=1 and illegal_i=1:
  - valid_o=1, illegal_o=1.
  - reg_write_o, mem_write_o, mem_read_o, branch_o, jump_o forced to 0, so no architectural side effects.
  - Remaining fields pass through.
- bubble_cnt_o:
  - Increments by 1 on each edge where a bubble is loaded due to flush_i or hz, and not rst.
  - Saturates at 2^CNT_W-1, with no wrap.
  - Flush and hazard in the same cycle count once.
- A load in EX with rd_addr_o=0 never stalls.
- Back-to-back dependent instructions stall exactly one cycle. After the bubble, mem_read_o=0, so hz deasserts.
- Reset mid-stall: stall_o drops the same cycle rst is high. The next cycle starts from the reset state with no pending bubble.

Test Plan:
1. Reset: assert rst 2 cycles with random inputs -> all outputs 0, stall_o=0, bubble_cnt_o=0.
2. Pass-through: valid_i=1, R-type controls (reg_write=1, alu_op=1), pc_i=0x100, rs1_data_i=0xDEADBEEF -> next cycle valid_o=1, reg_write_o=1, alu_op_o=1, pc_o=0x100, rs1_data_o=0xDEADBEEF, stall_o=0.
3. Load-use: cycle N lw x5 loads; cycle N+1 add with rs2=x5 and uses_rs2_i=1 -> stall_o=1 during N+1. At N+2: valid_o=0, all controls 0, bubble_cnt_o=1. Add re-presented at N+2 -> stall_o=0, add reaches the outputs at N+3. Repeat with rd=x0 -> no stall.
4. Flush priority: hazard condition plus flush_i=1 in the same cycle -> stall_o=0, bubble loaded, bubble_cnt_o increments by exactly 1.
5. Illegal opcode: valid_i=1, illegal_i=1, reg_write_i=1, mem_write_i=1, jump_i=01 -> valid_o=1, illegal_o=1, reg_write_o=0, mem_write_o=0, jump_o=00.
6. Saturation: CNT_W=2, five consecutive flushes -> bubble_cnt_o sequence 1,2,3,3,3.
